// File: rtl/fetch_pkg.sv
// fetch_pkg: constants and the fetch-entry type shared by the fetch unit and
// its output buffer.
package fetch_pkg;

  // Byte distance between consecutive instructions.
  localparam int unsigned PC_INC = 4;

  // Canonical NOP (addi x0, x0, 0), carried by misaligned-target markers.
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  // First fetch address after reset unless the instance overrides it.
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // One entry as presented to decode, default 32-bit widths.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        misalign;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: decode-facing output register plus a one-entry skid buffer.
// A response lands in the output register when that register is empty or
// being drained this cycle; otherwise it parks in the skid. On a transfer the
// skid moves forward into the output register on the same edge. flush_i drops
// both entries; if in_valid_i is high during a flush, that entry seeds the
// output register instead (used for the misaligned-target marker).
module fetch_skid_buf
  import fetch_pkg::*;
#(
  parameter type entry_t = fetch_entry_t
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   flush_i,
  input  logic   in_valid_i,
  input  entry_t in_entry_i,
  output logic   skid_valid_o,
  output logic   out_valid_o,
  input  logic   out_ready_i,
  output entry_t out_entry_o
);

  logic   out_valid_q;
  logic   out_valid_d;
  entry_t out_entry_q;
  entry_t out_entry_d;
  logic   skid_valid_q;
  logic   skid_valid_d;
  entry_t skid_entry_q;
  entry_t skid_entry_d;

  logic transfer;
  logic out_free;

  assign transfer = out_valid_q && out_ready_i;
  assign out_free = !out_valid_q || out_ready_i;

  // Next-state of the output register and the skid entry.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_entry_d  = out_entry_q;
    skid_valid_d = skid_valid_q;
    skid_entry_d = skid_entry_q;

    if (flush_i) begin
      skid_valid_d = 1'b0;
      out_valid_d  = in_valid_i;
      if (in_valid_i) begin
        out_entry_d = in_entry_i;
      end
    end else begin
      // Drain: the skid (if any) steps forward into the output register.
      if (transfer) begin
        out_valid_d  = skid_valid_q;
        skid_valid_d = 1'b0;
        if (skid_valid_q) begin
          out_entry_d = skid_entry_q;
        end
      end
      // Arrival. The issue logic never lets a response arrive while the skid
      // is full, so an arrival never collides with a skid-to-output move.
      if (in_valid_i) begin
        if (out_free) begin
          out_valid_d = 1'b1;
          out_entry_d = in_entry_i;
        end else begin
          skid_valid_d = 1'b1;
          skid_entry_d = in_entry_i;
        end
      end
    end
  end

  // Buffer state registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_entry_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_entry_q <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_entry_q  <= out_entry_d;
      skid_valid_q <= skid_valid_d;
      skid_entry_q <= skid_entry_d;
    end
  end

  assign out_valid_o  = out_valid_q;
  assign out_entry_o  = out_entry_q;
  assign skid_valid_o = skid_valid_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: sequential instruction fetch from a registered instruction
// memory, with redirect and a valid/ready hand-off to decode.
// Optional build macro FETCH_MISALIGN_CHK_EN: a redirect to a target that is
// not 4-byte aligned halts fetch and presents a single misaligned-target
// marker entry. Without it the low two target bits are forced to zero.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_inst,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  id_valid,
  input  logic                  id_ready,
  output logic [ADDR_WIDTH-1:0] id_pc,
  output logic [DATA_WIDTH-1:0] id_inst,
  output logic                  id_misalign
);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] inst;
    logic                  misalign;
  } entry_t;

  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] pc_d;
  logic [ADDR_WIDTH-1:0] resp_pc_q;
  logic [ADDR_WIDTH-1:0] resp_pc_d;
  logic                  resp_valid_q;
  logic                  resp_valid_d;
  logic                  halt_q;

  logic [ADDR_WIDTH-1:0] redir_target;
  logic                  redir_misalign;
  logic                  skid_valid;
  logic                  issue_en;
  logic                  buf_in_valid;
  entry_t                buf_in_entry;
  entry_t                buf_out_entry;

`ifdef FETCH_MISALIGN_CHK_EN
  logic halt_d;

  assign redir_target   = redirect_pc;
  assign redir_misalign = (redirect_pc[1:0] != 2'b00);
  // Every redirect re-decides the halt: set by a misaligned target, cleared otherwise.
  assign halt_d         = redirect_valid ? redir_misalign : halt_q;

  // Halt flag: blocks issue after a misaligned redirect until the next redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halt_q <= 1'b0;
    end else begin
      halt_q <= halt_d;
    end
  end
`else
  assign redir_target   = redirect_pc & ~ADDR_WIDTH'(3);
  assign redir_misalign = 1'b0;
  assign halt_q         = 1'b0;
`endif

  // Issue only when nothing can be lost: no redirect, not halted, skid empty,
  // and the in-flight response (if any) is guaranteed a landing slot.
  assign issue_en = !redirect_valid && !halt_q && !skid_valid &&
                    !(resp_valid_q && id_valid && !id_ready);

  // PC and response-tracking next state; redirect wins over issue.
  always_comb begin
    pc_d         = pc_q;
    resp_pc_d    = resp_pc_q;
    resp_valid_d = 1'b0;
    if (redirect_valid) begin
      pc_d = redir_target;
    end else if (issue_en) begin
      pc_d         = pc_q + ADDR_WIDTH'(PC_INC);
      resp_pc_d    = pc_q;
      resp_valid_d = 1'b1;
    end
  end

  // PC and in-flight response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC;
      resp_pc_q    <= '0;
      resp_valid_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      resp_pc_q    <= resp_pc_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  // Buffer input: the memory response normally; during a redirect the
  // in-flight response is dropped and only a misaligned marker may enter.
  always_comb begin
    buf_in_valid          = resp_valid_q;
    buf_in_entry.pc       = resp_pc_q;
    buf_in_entry.inst     = imem_inst;
    buf_in_entry.misalign = 1'b0;
    if (redirect_valid) begin
      buf_in_valid          = redir_misalign;
      buf_in_entry.pc       = redirect_pc;
      buf_in_entry.inst     = DATA_WIDTH'(NOP_INST);
      buf_in_entry.misalign = redir_misalign;
    end
  end

  fetch_skid_buf #(
    .entry_t (entry_t)
  ) u_skid_buf (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (redirect_valid),
    .in_valid_i   (buf_in_valid),
    .in_entry_i   (buf_in_entry),
    .skid_valid_o (skid_valid),
    .out_valid_o  (id_valid),
    .out_ready_i  (id_ready),
    .out_entry_o  (buf_out_entry)
  );

  assign imem_addr   = pc_q;
  assign id_pc       = buf_out_entry.pc;
  assign id_inst     = buf_out_entry.inst;
  assign id_misalign = buf_out_entry.misalign;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, PC and instruction-memory address width.
REQ-002 Parameter DATA_WIDTH, default 32, instruction width.
REQ-003 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 imem_addr  out  ADDR_WIDTH  fetch address to instruction memory; combinationally equal to pc_q.
REQ-007 imem_inst  in  DATA_WIDTH  instruction memory read data; registered memory, valid one cycle after imem_addr.
REQ-008 redirect_valid  in  1  branch/jump/trap redirect request.
REQ-009 redirect_pc  in  ADDR_WIDTH  redirect target.
REQ-010 id_valid  out  1  decode-side entry valid.
REQ-011 id_ready  in  1  decode accepts the entry; transfer when id_valid && id_ready.
REQ-012 id_pc  out  ADDR_WIDTH  PC of the presented instruction.
REQ-013 id_inst  out  DATA_WIDTH  presented instruction.
REQ-014 id_misalign  out  1  presented entry is a misaligned-target marker.

Function
REQ-015 Issue: issue_en = !redirect_valid && !halt_q && !skid_valid && !(resp_valid && id_valid && !id_ready); on issue, pc_q <= pc_q + 4 (modulo 2^ADDR_WIDTH wrap) and resp_valid <= 1, else resp_valid <= 0.
REQ-016 resp_pc register captures pc_q on issue; response data is imem_inst in the following cycle.
REQ-017 Response landing: to the output register if !id_valid or id_ready; otherwise to the one-entry skid buffer.
REQ-018 On output transfer with skid valid, skid moves to the output register in the same edge; the skid is then empty.
REQ-019 Skid never overflows: a response never arrives while the skid is full (guaranteed by REQ-015).
REQ-020 Throughput: with id_ready held 1, one instruction per cycle, consecutive PCs +4.
REQ-021 Latency: redirect or reset release at edge T -> imem_addr = target during cycle T+1 -> id_valid with that target at cycle T+2.
REQ-022 id_valid, id_pc, id_inst are held stable while id_valid && !id_ready.
REQ-023 Redirect has top priority: pc_q <= redirect_pc, in-flight response dropped, skid and output cleared (id_valid <= 0), halt_q cleared, even if id_ready is 1 in the same cycle.
REQ-024 Redirect held over multiple cycles re-targets each cycle; fetch starts in the cycle after the last redirect cycle.

Reset
REQ-025 Asynchronous on rst_n low: pc_q = RESET_PC, resp_valid = 0, skid_valid = 0, id_valid = 0, id_pc = 0, id_inst = 0, id_misalign = 0, halt_q = 0.
REQ-026 Reset mid-stream discards all in-flight and buffered entries; memory output during reset is ignored.

Configuration
REQ-027 Macro FETCH_MISALIGN_CHK_EN defined: redirect_pc[1:0] != 0 sets pc_q = redirect_pc and halt_q = 1; the next cycle the block presents one entry id_valid = 1, id_misalign = 1, id_pc = redirect_pc, id_inst = 32'h0000_0013; no further issue until the next redirect.
REQ-028 Macro undefined: redirect_pc[1:0] forced to 2'b00, halt_q constant 0, id_misalign tied 0.

Structure
REQ-029 Shared package fetch_pkg: PC_INC (4), NOP_INST (32'h0000_0013), default RESET_PC, and the fetch-entry struct {pc, inst, misalign}.
REQ-030 One sub-module fetch_skid_buf holds the output register and skid entry with the valid/ready logic; fetch_unit holds pc_q, issue, and redirect logic.

Verification
REQ-031 Reset release, id_ready = 1: imem_addr 0x0,0x4,0x8...; id_valid first at cycle 2, id_pc 0x0, then one per cycle with matching memory words.
REQ-032 id_ready low for 5 cycles mid-stream: id_pc held; skid fills once, issue stops; on release, PCs continue with no gap or duplicate.
REQ-033 Redirect to 0x100 while output is stalled with a full skid: both dropped, id_valid 0 next cycle, id_pc 0x100 at T+2.
REQ-034 Redirect and id_ready = 1 in the same cycle: the old entry is not transferred, and the next entry is 0x100.
REQ-035 With FETCH_MISALIGN_CHK_EN, redirect to 0x102: one entry with id_misalign = 1 and id_inst 0x00000013, then id_valid stays 0 until a redirect to 0x200 resumes fetch.
REQ-036 PC 0xFFFF_FFFC issue wraps to 0x0000_0000; rst_n asserted mid-stream clears id_valid immediately, asynchronously.
